// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame FSM states, frame geometry, parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_DATA_BITS  = 8;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with separate occupancy counter; dout reads 0 when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A pop frees a slot in the same cycle, so a full FIFO may still accept a push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers wrap naturally at power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise, filter clock, deframe 11-bit frames, queue good bytes.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd,
    input  logic                          clr_err,
    output logic [PS2_DATA_BITS-1:0]      data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          parity_err
);

    localparam int unsigned FCW = $clog2(FILTER_LEN);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]               clk_sync_q, data_sync_q;
    logic                     filt_q, filt_d, filt_prev_q;
    logic [FCW-1:0]           filt_cnt_q, filt_cnt_d;
    ps2_state_e               state_q, state_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
    logic                     parity_q, parity_d;
    logic [TCW-1:0]           to_cnt_q, to_cnt_d;
    logic                     push_q;
    logic [PS2_DATA_BITS-1:0] push_byte_q;
    logic                     overflow_q, parity_err_q;
    logic                     strobe, bit_in, frame_good, frame_bad;
    logic                     fifo_full, fifo_empty, pop, ovf_evt;

    assign bit_in = data_sync_q[1];
    assign strobe = filt_prev_q & ~filt_q;

    // Two-flop synchronisers for both raw pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    // Filter state and the delayed copy used for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            filt_cnt_q  <= filt_cnt_d;
        end
    end

    // Frame FSM next state; advances on strobes, aborts silently on inter-bit timeout.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        to_cnt_d   = '0;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (!bit_in) begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {bit_in, shift_q[PS2_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = bit_in;
                    state_d  = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (bit_in && odd_parity_ok(shift_q, parity_q)) frame_good = 1'b1;
                    else                                            frame_bad  = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q != StIdle) begin
            if (to_cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                state_d = StIdle;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    // Frame FSM registers plus the one-cycle-delayed push of a good byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            to_cnt_q  <= to_cnt_d;
            push_q    <= frame_good;
            if (frame_good) push_byte_q <= shift_q;
        end
    end

    assign pop     = rd & ~fifo_empty;
    assign ovf_evt = push_q & fifo_full & ~pop;

    // Sticky error flags; a new event wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (ovf_evt)      overflow_q <= 1'b1;
            else if (clr_err) overflow_q <= 1'b0;
            if (frame_bad)    parity_err_q <= 1'b1;
            else if (clr_err) parity_err_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (PS2_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push_q),
        .pop_i   (pop),
        .din_i   (push_byte_q),
        .dout_o  (data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    assign ready      = ~fifo_empty;
    assign overflow   = overflow_q;
    assign parity_err = parity_err_q;

endmodule
